// File: rtl/multicycle_sequencer.sv
// Multi-cycle RV32 control sequencer: PC, IF/RR/EX/MA/MW/RW/HALT stage machine and strobes.
// Define SEQ_RETIRE_COUNTER_EN to build the 64-bit retired-instruction counter.
module multicycle_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_8000,
  parameter logic [31:0] MMIO_BASE   = 32'hF6FF_F000,
  parameter logic [31:0] MMIO_SIZE   = 32'h0000_1000,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        sysclk,
  input  logic        nrst,
  input  logic        run_i,
  input  logic [31:0] npc_i,
  input  logic        is_load_i,
  input  logic        is_store_i,
  input  logic        is_halt_i,
  input  logic        reg_we_dec_i,
  input  logic [31:0] mem_addr_i,
  input  logic        mem_ready_i,
  output logic [31:0] pc_o,
  output logic [2:0]  stage_o,
  output logic        dec_rst_o,
  output logic        alu_rst_o,
  output logic        ram_we_o,
  output logic        mmio_we_o,
  output logic        mmio_sel_o,
  output logic        reg_we_o,
  output logic        halted_o,
  output logic        bus_err_o,
  output logic [63:0] retired_o
);

  localparam logic [2:0] S_IF   = 3'd0;
  localparam logic [2:0] S_RR   = 3'd1;
  localparam logic [2:0] S_EX   = 3'd2;
  localparam logic [2:0] S_MA   = 3'd3;
  localparam logic [2:0] S_MW   = 3'd4;
  localparam logic [2:0] S_RW   = 3'd5;
  localparam logic [2:0] S_HALT = 3'd6;

  localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMO = CW'(MEM_TIMEOUT);

  logic [2:0]    state;
  logic [CW-1:0] wait_cnt;
  logic [CW-1:0] cnt_inc;
  logic          hit;
  logic          mem_op;
  logic          tmo_hit;

  assign stage_o = state;
  assign hit     = (mem_addr_i & ~(MMIO_SIZE - 32'd1)) == MMIO_BASE;
  assign mem_op  = is_load_i | is_store_i;
  assign cnt_inc = wait_cnt + CW'(1);
  // Timeout fires on the MW cycle whose increment would reach the limit.
  assign tmo_hit = (MEM_TIMEOUT != 0) && (cnt_inc == TMO);

  always_ff @(posedge sysclk or negedge nrst) begin
    if (!nrst) begin
      state      <= S_IF;
      pc_o       <= RESET_PC;
      wait_cnt   <= '0;
      dec_rst_o  <= 1'b0;
      alu_rst_o  <= 1'b0;
      ram_we_o   <= 1'b0;
      mmio_we_o  <= 1'b0;
      mmio_sel_o <= 1'b0;
      reg_we_o   <= 1'b0;
      halted_o   <= 1'b0;
      bus_err_o  <= 1'b0;
    end else begin
      // Strobes are registered one edge early so they are high during their stage.
      dec_rst_o <= 1'b0;
      alu_rst_o <= 1'b0;
      ram_we_o  <= 1'b0;
      mmio_we_o <= 1'b0;
      reg_we_o  <= 1'b0;
      case (state)
        S_IF: begin
          if (run_i) begin
            state     <= S_RR;
            dec_rst_o <= 1'b1;
          end
        end
        S_RR: begin
          state     <= S_EX;
          alu_rst_o <= 1'b1;
        end
        S_EX: begin
          state      <= S_MA;
          ram_we_o   <= is_store_i & ~hit;
          mmio_we_o  <= is_store_i & hit;
          mmio_sel_o <= hit & mem_op;
        end
        S_MA: begin
          if (!mem_op || hit || mem_ready_i) begin
            state    <= S_RW;
            reg_we_o <= reg_we_dec_i;
          end else begin
            state    <= S_MW;
            wait_cnt <= '0;
          end
        end
        S_MW: begin
          if (mem_ready_i) begin
            state    <= S_RW;
            reg_we_o <= reg_we_dec_i;
          end else if (tmo_hit) begin
            state      <= S_HALT;
            bus_err_o  <= 1'b1;
            halted_o   <= 1'b1;
            mmio_sel_o <= 1'b0;
          end else begin
            wait_cnt <= cnt_inc;
          end
        end
        S_RW: begin
          mmio_sel_o <= 1'b0;
          if (is_halt_i) begin
            state    <= S_HALT;
            halted_o <= 1'b1;
          end else begin
            pc_o  <= npc_i;
            state <= S_IF;
          end
        end
        S_HALT: state <= S_HALT;
        default: state <= S_HALT;
      endcase
    end
  end

`ifdef SEQ_RETIRE_COUNTER_EN
  logic [63:0] retired_q;

  always_ff @(posedge sysclk or negedge nrst) begin
    if (!nrst)
      retired_q <= '0;
    else if (state == S_RW)
      retired_q <= retired_q + 64'd1;
  end

  assign retired_o = retired_q;
`else
  assign retired_o = 64'd0;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed self-checking bench for multicycle_sequencer (MEM_TIMEOUT=4).
module tb_multicycle_sequencer;

  logic        sysclk = 1'b0;
  logic        nrst = 1'b1;
  logic        run_i = 1'b0;
  logic [31:0] npc_i = '0;
  logic        is_load_i = 1'b0;
  logic        is_store_i = 1'b0;
  logic        is_halt_i = 1'b0;
  logic        reg_we_dec_i = 1'b0;
  logic [31:0] mem_addr_i = '0;
  logic        mem_ready_i = 1'b0;
  logic [31:0] pc_o;
  logic [2:0]  stage_o;
  logic        dec_rst_o, alu_rst_o, ram_we_o, mmio_we_o, mmio_sel_o, reg_we_o;
  logic        halted_o, bus_err_o;
  logic [63:0] retired_o;

  always #5 sysclk = ~sysclk;

  multicycle_sequencer #(.MEM_TIMEOUT(4)) dut (
    .sysclk(sysclk), .nrst(nrst), .run_i(run_i), .npc_i(npc_i),
    .is_load_i(is_load_i), .is_store_i(is_store_i), .is_halt_i(is_halt_i),
    .reg_we_dec_i(reg_we_dec_i), .mem_addr_i(mem_addr_i), .mem_ready_i(mem_ready_i),
    .pc_o(pc_o), .stage_o(stage_o), .dec_rst_o(dec_rst_o), .alu_rst_o(alu_rst_o),
    .ram_we_o(ram_we_o), .mmio_we_o(mmio_we_o), .mmio_sel_o(mmio_sel_o),
    .reg_we_o(reg_we_o), .halted_o(halted_o), .bus_err_o(bus_err_o),
    .retired_o(retired_o)
  );

  int checks = 0;
  int failures = 0;
  int r_cyc, r_mw, r_ram, r_mmio, r_reg, r_sel, r_bad;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge sysclk);
    #1;
  endtask

  task automatic exp_retired(input string tag, input logic [63:0] n);
`ifdef SEQ_RETIRE_COUNTER_EN
    chk(tag, retired_o, n);
`else
    chk(tag, retired_o, 64'd0);
`endif
  endtask

  // Runs one instruction from IF; ready goes high after rl low MA/MW cycles (rl<0: never).
  task automatic run_instr(input int rl);
    int lc = 0;
    bit done = 1'b0;
    r_cyc = 0; r_mw = 0; r_ram = 0; r_mmio = 0; r_reg = 0; r_sel = 0; r_bad = 0;
    mem_ready_i = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      r_cyc++;
      r_mw   += int'(stage_o == 3'd4);
      r_ram  += int'(ram_we_o && stage_o == 3'd3);
      r_mmio += int'(mmio_we_o && stage_o == 3'd3);
      r_reg  += int'(reg_we_o && stage_o == 3'd5);
      r_sel  += int'(mmio_sel_o);
      r_bad  += int'((ram_we_o || mmio_we_o) && stage_o != 3'd3);
      r_bad  += int'(reg_we_o && stage_o != 3'd5);
      r_bad  += int'(dec_rst_o && stage_o != 3'd1);
      r_bad  += int'(alu_rst_o && stage_o != 3'd2);
      if (stage_o == 3'd3 || stage_o == 3'd4) begin
        mem_ready_i = (rl >= 0) && (lc >= rl);
        lc++;
      end else begin
        mem_ready_i = 1'b0;
      end
      if (stage_o == 3'd0 || stage_o == 3'd6) begin
        done = 1'b1;
        break;
      end
    end
    chk("instr_done", done, 1'b1);
  endtask

  task automatic check_frozen(input string tag, input logic [31:0] pc);
    int dev = 0;
    for (int i = 0; i < 6; i++) begin
      run_i = i[0];
      step();
      dev += int'(stage_o != 3'd6 || pc_o != pc);
      dev += int'(dec_rst_o | alu_rst_o | ram_we_o | mmio_we_o | reg_we_o | mmio_sel_o);
    end
    chk(tag, dev, 0);
  endtask

  initial begin
    #2 nrst = 1'b0;
    #1;
    chk("rst_stage", stage_o, 3'd0);
    chk("rst_pc", pc_o, 32'h8000);
    chk("rst_strobes", {dec_rst_o, alu_rst_o, ram_we_o, mmio_we_o, mmio_sel_o, reg_we_o}, 6'd0);
    chk("rst_status", {halted_o, bus_err_o}, 2'd0);
    exp_retired("rst_retired", 0);
    step(); step();
    nrst = 1'b1;

    // ALU op, walked cycle by cycle
    run_i = 1'b1; npc_i = 32'h8004; reg_we_dec_i = 1'b1;
    step(); chk("t1_rr", stage_o, 3'd1); chk("t1_dec", dec_rst_o, 1'b1);
    step(); chk("t1_ex", stage_o, 3'd2); chk("t1_alu", alu_rst_o, 1'b1); chk("t1_dec0", dec_rst_o, 1'b0);
    step(); chk("t1_ma", stage_o, 3'd3); chk("t1_reg_ma", reg_we_o, 1'b0);
    step(); chk("t1_rw", stage_o, 3'd5); chk("t1_reg_rw", reg_we_o, 1'b1); chk("t1_pc_rw", pc_o, 32'h8000);
    step(); chk("t1_if", stage_o, 3'd0); chk("t1_pc", pc_o, 32'h8004); chk("t1_reg_if", reg_we_o, 1'b0);
    exp_retired("t1_retired", 1);

    // RAM store, ready low for 3 cycles
    is_store_i = 1'b1; mem_addr_i = 32'h0000_0100; npc_i = 32'h8008; reg_we_dec_i = 1'b0;
    run_instr(3);
    chk("t2_cpi", r_cyc, 8); chk("t2_mw", r_mw, 3); chk("t2_ram", r_ram, 1);
    chk("t2_mmio", r_mmio, 0); chk("t2_sel", r_sel, 0); chk("t2_bad", r_bad, 0);
    chk("t2_pc", pc_o, 32'h8008);

    // MMIO store never waits
    mem_addr_i = 32'hF6FF_F070; npc_i = 32'h800C;
    run_instr(-1);
    chk("t3_cpi", r_cyc, 5); chk("t3_mw", r_mw, 0); chk("t3_mmio", r_mmio, 1);
    chk("t3_ram", r_ram, 0); chk("t3_sel", r_sel, 2); chk("t3_bad", r_bad, 0);
    chk("t3_pc", pc_o, 32'h800C);

    // Load: ready arrives in the same MW cycle the timeout would fire
    is_store_i = 1'b0; is_load_i = 1'b1; mem_addr_i = 32'h0000_0300;
    reg_we_dec_i = 1'b1; npc_i = 32'h8010;
    run_instr(4);
    chk("t4_cpi", r_cyc, 9); chk("t4_mw", r_mw, 4); chk("t4_stage", stage_o, 3'd0);
    chk("t4_reg", r_reg, 1); chk("t4_err", bus_err_o, 1'b0); chk("t4_pc", pc_o, 32'h8010);
    chk("t4_bad", r_bad, 0);

    // Load timeout -> HALT
    mem_addr_i = 32'h0000_0400; npc_i = 32'h9000;
    run_instr(-1);
    chk("t5_stage", stage_o, 3'd6); chk("t5_cyc", r_cyc, 8); chk("t5_mw", r_mw, 4);
    chk("t5_reg", r_reg, 0); chk("t5_err", bus_err_o, 1'b1); chk("t5_halted", halted_o, 1'b1);
    chk("t5_pc", pc_o, 32'h8010); chk("t5_bad", r_bad, 0);
    exp_retired("t5_retired", 4);
    check_frozen("t5_frozen", 32'h8010);

    nrst = 1'b0;
    #1;
    chk("t6_rst_pc", pc_o, 32'h8000); chk("t6_rst_stage", stage_o, 3'd0);
    chk("t6_rst_status", {halted_o, bus_err_o}, 2'd0);
    exp_retired("t6_rst_retired", 0);
    step(); step();
    nrst = 1'b1;

    // Halt instruction
    is_load_i = 1'b0; is_halt_i = 1'b1; reg_we_dec_i = 1'b1; npc_i = 32'h8020;
    mem_addr_i = 32'h0; run_i = 1'b1;
    run_instr(-1);
    chk("t7_stage", stage_o, 3'd6); chk("t7_cyc", r_cyc, 5); chk("t7_reg", r_reg, 1);
    chk("t7_halted", halted_o, 1'b1); chk("t7_err", bus_err_o, 1'b0);
    chk("t7_pc", pc_o, 32'h8000); chk("t7_bad", r_bad, 0);
    exp_retired("t7_retired", 1);
    check_frozen("t7_frozen", 32'h8000);

    // Stall in IF, then release
    run_i = 1'b0; is_halt_i = 1'b0;
    nrst = 1'b0;
    #1;
    chk("t8_rst_stage", stage_o, 3'd0);
    step();
    nrst = 1'b1;
    begin
      int moved = 0;
      for (int i = 0; i < 10; i++) begin
        step();
        moved += int'(stage_o != 3'd0 || dec_rst_o);
      end
      chk("t8_idle", moved, 0);
    end
    run_i = 1'b1;
    step();
    chk("t8_rr", stage_o, 3'd1); chk("t8_dec", dec_rst_o, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
